// File: rtl/gin_config_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : gin_config_sequencer_if
// Description : Bundles the GIN configuration sequencer's control, ID-SRAM,
//               scan-chain and stream signals.
//               master modport - sequencer view (drives strobes, tags, GIN side)
//               slave  modport - environment view (controller, SRAM, source, GIN)
// Ports       : start/cfg_* (request), busy/done (status), id_rd_* (ID SRAM),
//               set_XID/XID_scan_in/set_YID/YID_scan_in (scan chains),
//               src_* / GIN_* / tag_X / tag_Y (stream)
// Revision    : 1.0 - initial release
// ============================================================================
interface gin_config_sequencer_if #(
    parameter int NUM_ROW   = 6,
    parameter int NUM_COL   = 8,
    parameter int XID_BITS  = 5,
    parameter int YID_BITS  = 5,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 16
);
    localparam int ID_W = (XID_BITS > YID_BITS) ? XID_BITS : YID_BITS;
    localparam int AW   = $clog2(NUM_ROW * NUM_COL + NUM_ROW);

    logic                 start;
    logic                 cfg_scan;
    logic [XID_BITS-1:0]  cfg_num_x;
    logic [YID_BITS-1:0]  cfg_num_y;
    logic [LEN_BITS-1:0]  cfg_len;
    logic                 busy;
    logic                 done;
    logic                 id_rd_en;
    logic [AW-1:0]        id_rd_addr;
    logic [ID_W-1:0]      id_rd_data;
    logic                 set_XID;
    logic [XID_BITS-1:0]  XID_scan_in;
    logic                 set_YID;
    logic [YID_BITS-1:0]  YID_scan_in;
    logic                 src_valid;
    logic                 src_ready;
    logic [DATA_BITS-1:0] src_data;
    logic                 GIN_valid;
    logic                 GIN_ready;
    logic [DATA_BITS-1:0] GIN_data;
    logic [XID_BITS-1:0]  tag_X;
    logic [YID_BITS-1:0]  tag_Y;

    modport master (
        input  start, cfg_scan, cfg_num_x, cfg_num_y, cfg_len,
        input  id_rd_data, src_valid, src_data, GIN_ready,
        output busy, done, id_rd_en, id_rd_addr,
        output set_XID, XID_scan_in, set_YID, YID_scan_in,
        output src_ready, GIN_valid, GIN_data, tag_X, tag_Y
    );

    modport slave (
        output start, cfg_scan, cfg_num_x, cfg_num_y, cfg_len,
        output id_rd_data, src_valid, src_data, GIN_ready,
        input  busy, done, id_rd_en, id_rd_addr,
        input  set_XID, XID_scan_in, set_YID, YID_scan_in,
        input  src_ready, GIN_valid, GIN_data, tag_X, tag_Y
    );
endinterface
`default_nettype wire

// File: rtl/gin_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gin_config_sequencer
// Description : Per-layer GIN sequencer. Optionally reads the PE ID table from
//               the ID SRAM and shifts it into the X then Y ID scan chains,
//               then forwards cfg_len source beats to the GIN with per-beat
//               tag_X/tag_Y, and finally pulses done for one cycle.
// Ports       : clk, rst (sync, active-high)
//               bus - gin_config_sequencer_if.master (control, SRAM, scan,
//                     stream signals)
// Revision    : 1.0 - initial release
// ============================================================================
module gin_config_sequencer #(
    parameter int NUM_ROW   = 6,
    parameter int NUM_COL   = 8,
    parameter int XID_BITS  = 5,
    parameter int YID_BITS  = 5,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    gin_config_sequencer_if.master bus
);
    localparam int c_nx    = NUM_ROW * NUM_COL;
    localparam int c_total = c_nx + NUM_ROW;
    localparam int c_aw    = $clog2(c_total);
    // One extra bit so the read counter can sit at c_total when the table is
    // exhausted, even when c_total is a power of two.
    localparam int c_cw    = c_aw + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [XID_BITS-1:0]  r_num_x;
    logic [YID_BITS-1:0]  r_num_y;
    logic [LEN_BITS-1:0]  r_len;
    logic [c_cw-1:0]      r_rd_cnt;
    logic                 r_sh_vld;
    logic                 r_sh_y;
    logic                 r_sh_last;
    logic [LEN_BITS-1:0]  r_beat_cnt;
    logic [XID_BITS-1:0]  r_tag_x;
    logic [YID_BITS-1:0]  r_tag_y;
    logic [DATA_BITS-1:0] w_data;

    logic                 w_rd_en;
    logic                 w_hs;
    logic                 w_last_beat;
    logic                 w_x_wrap;
    logic                 w_y_wrap;

    assign w_rd_en     = (r_state == S_SCAN) && (r_rd_cnt < c_cw'(c_total));
    assign w_hs        = (r_state == S_STREAM) && bus.src_valid && bus.GIN_ready;
    assign w_last_beat = w_hs && (r_beat_cnt == r_len - 1'b1);
    // A period of 0 or 1 keeps the tag pinned at 0.
    assign w_x_wrap    = (r_num_x <= XID_BITS'(1)) || (r_tag_x == r_num_x - 1'b1);
    assign w_y_wrap    = (r_num_y <= YID_BITS'(1)) || (r_tag_y == r_num_y - 1'b1);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM next state / decoded outputs ----------------
    always_comb begin
        w_next        = r_state;
        bus.busy      = (r_state != S_IDLE);
        bus.done      = (r_state == S_DONE);
        bus.id_rd_en  = w_rd_en;
        bus.src_ready = bus.GIN_ready && (r_state == S_STREAM);
        bus.GIN_valid = bus.src_valid && (r_state == S_STREAM);
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_scan)             w_next = S_SCAN;
                    else if (bus.cfg_len != '0)   w_next = S_STREAM;
                    else                          w_next = S_DONE;
                end
            end
            S_SCAN: begin
                if (r_sh_vld && r_sh_last) begin
                    w_next = (r_len != '0) ? S_STREAM : S_DONE;
                end
            end
            S_STREAM: begin
                if (w_last_beat) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_x    <= '0;
            r_num_y    <= '0;
            r_len      <= '0;
            r_rd_cnt   <= '0;
            r_sh_vld   <= 1'b0;
            r_sh_y     <= 1'b0;
            r_sh_last  <= 1'b0;
            r_beat_cnt <= '0;
            r_tag_x    <= '0;
            r_tag_y    <= '0;
        end else begin
            if ((r_state == S_IDLE) && bus.start) begin
                r_num_x  <= bus.cfg_num_x;
                r_num_y  <= bus.cfg_num_y;
                r_len    <= bus.cfg_len;
                r_rd_cnt <= '0;
            end else if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            // Shift stage trails the read by one cycle, matching SRAM latency.
            r_sh_vld  <= w_rd_en;
            r_sh_y    <= (r_rd_cnt >= c_cw'(c_nx));
            r_sh_last <= (r_rd_cnt == c_cw'(c_total - 1));

            if (r_state != S_STREAM) begin
                r_beat_cnt <= '0;
                r_tag_x    <= '0;
                r_tag_y    <= '0;
            end else if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (w_x_wrap) begin
                    r_tag_x <= '0;
                    r_tag_y <= w_y_wrap ? '0 : r_tag_y + 1'b1;
                end else begin
                    r_tag_x <= r_tag_x + 1'b1;
                end
            end
        end
    end

    assign w_data          = bus.src_data;
    assign bus.GIN_data    = w_data;
    assign bus.id_rd_addr  = r_rd_cnt[c_aw-1:0];
    assign bus.set_XID     = r_sh_vld && !r_sh_y;
    assign bus.set_YID     = r_sh_vld && r_sh_y;
    assign bus.XID_scan_in = bus.id_rd_data[XID_BITS-1:0];
    assign bus.YID_scan_in = bus.id_rd_data[YID_BITS-1:0];
    assign bus.tag_X       = r_tag_x;
    assign bus.tag_Y       = r_tag_y;
endmodule
`default_nettype wire
